spi_master_mc: RTL and testbench

Parametrised, single-clock SPI master. It serialises a DATA_W-bit word onto mosi with a programmable SCLK divider, a per-transfer SPI mode (CPOL/CPHA) and a one-hot chip-select across NUM_CS slaves. It optionally captures miso full-duplex. It sits between a local command source (valid/ready) and off-chip SPI slaves, and generates SCLK as a register in the clk domain rather than using a divided clock.

---
 rtl/spi_pkg.sv | 24 ++
 rtl/spi_sclk_gen.sv | 80 ++++++++
 rtl/spi_master_mc.sv | 187 ++++++++++++++++++
 tb/tb_spi_master_mc.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types for the spi_master_mc SPI master: FSM state encoding and
// the per-transfer SPI mode record.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD  = 3'd1,
        XFER  = 3'd2,
        TRAIL = 3'd3,
        DONE  = 3'd4
    } spi_state_t;

    // Bit order matches the {CPOL,CPHA} mode input so a plain cast works.
    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    // Width of a slave index that can address num_cs selects (minimum 1 bit).
    function automatic int cs_index_width(input int num_cs);
        return (num_cs > 1) ? $clog2(num_cs) : 1;
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator for spi_master_mc. Holds the half-period counter, the sclk
// register and the SCLK edge counter. The half-period counter also times the
// LEAD and TRAIL phases (cnt_en high, run low), in which sclk does not move.
// Edge strobes are combinational and valid in the cycle whose closing clk
// edge toggles sclk: lead_edge marks odd edges (1,3,..), trail_edge even ones.
module spi_sclk_gen #(
    parameter int DATA_W  = 12,
    parameter int CLK_DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,        // transfer accepted: restart edge count, set new CPOL
    input  logic load_cpol,
    input  logic cpol_hold,   // stored CPOL of the last accepted transfer
    input  logic cnt_en,      // LEAD, XFER or TRAIL
    input  logic run,         // XFER: half-period expiry toggles sclk
    output logic sclk,
    output logic half_done,
    output logic lead_edge,
    output logic trail_edge,
    output logic last_edge
);

    localparam int HC_W = $clog2(CLK_DIV + 1);
    localparam int EC_W = $clog2(2 * DATA_W + 1);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(CLK_DIV - 1);
    localparam logic [EC_W-1:0] EC_LAST = EC_W'(2 * DATA_W - 1);

    logic [HC_W-1:0] hc_q, hc_d;
    logic [EC_W-1:0] ec_q, ec_d;
    logic            sclk_q, sclk_d;
    logic            toggle;

    assign half_done  = cnt_en && (hc_q == HC_LAST);
    assign toggle     = run && half_done;
    assign lead_edge  = toggle && !ec_q[0];
    assign trail_edge = toggle && ec_q[0];
    assign last_edge  = toggle && (ec_q == EC_LAST);
    assign sclk       = sclk_q;

    // Next-state for the half-period counter, edge counter and sclk level.
    always_comb begin
        hc_d = hc_q;
        if (!cnt_en || half_done) begin
            hc_d = '0;
        end else begin
            hc_d = hc_q + 1'b1;
        end

        ec_d = ec_q;
        if (load) begin
            ec_d = '0;
        end else if (toggle) begin
            ec_d = ec_q + 1'b1;
        end

        sclk_d = sclk_q;
        if (load) begin
            sclk_d = load_cpol;
        end else if (toggle) begin
            sclk_d = ~sclk_q;
        end else if (!cnt_en) begin
            sclk_d = cpol_hold;
        end
    end

    // Counter and sclk registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc_q   <= '0;
            ec_q   <= '0;
            sclk_q <= 1'b0;
        end else begin
            hc_q   <= hc_d;
            ec_q   <= ec_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/spi_master_mc.sv
// spi_master_mc: single-clock SPI master with programmable SCLK divider,
// per-transfer mode {CPOL,CPHA} and one-hot active-low chip selects.
// Optional receive path enabled by defining SPI_RX_EN; without it miso is
// ignored and dout is constant 0.
// Handshake: a transfer is accepted in the cycle where start && ready; ready
// is high only in IDLE, so a start seen while busy is dropped, never queued.
module spi_master_mc
    import spi_pkg::*;
#(
    parameter int DATA_W    = 12,
    parameter int CLK_DIV   = 10,
    parameter int NUM_CS    = 1,
    parameter int LSB_FIRST = 0,
    localparam int CS_W     = cs_index_width(NUM_CS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    input  logic [1:0]        mode,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              miso,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] dout,
    output logic              sclk,
    output logic [NUM_CS-1:0] cs_n,
    output logic              mosi
);

    spi_state_t        state_q, state_d;
    spi_mode_t         mode_q, mode_d, mode_in;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic              mosi_q, mosi_d;
    logic [NUM_CS-1:0] cs_n_q, cs_n_d;

    logic accept, cnt_en, run, enter_done;
    logic half_done, lead_edge, trail_edge, last_edge;

    // Bit that goes on the wire next from a transmit word.
    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return (LSB_FIRST != 0) ? w[0] : w[DATA_W-1];
    endfunction

    // Transmit word with the bit just sent removed.
    function automatic logic [DATA_W-1:0] shift_tx(input logic [DATA_W-1:0] w);
        return (LSB_FIRST != 0) ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
    endfunction

    // Active-low one-hot select; an index with no matching slave selects none.
    function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] idx);
        logic [NUM_CS-1:0] r;
        r = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (idx == CS_W'(i)) r[i] = 1'b0;
        end
        return r;
    endfunction

    assign mode_in    = spi_mode_t'(mode);
    assign accept     = start && (state_q == IDLE);
    assign cnt_en     = (state_q == LEAD) || (state_q == XFER) || (state_q == TRAIL);
    assign run        = (state_q == XFER);
    assign enter_done = (state_q == TRAIL) && half_done;

    assign ready = (state_q == IDLE);
    assign done  = (state_q == DONE);
    assign mosi  = mosi_q;
    assign cs_n  = cs_n_q;

    spi_sclk_gen #(
        .DATA_W  (DATA_W),
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (accept),
        .load_cpol  (mode_in.cpol),
        .cpol_hold  (mode_q.cpol),
        .cnt_en     (cnt_en),
        .run        (run),
        .sclk       (sclk),
        .half_done  (half_done),
        .lead_edge  (lead_edge),
        .trail_edge (trail_edge),
        .last_edge  (last_edge)
    );

    // Transfer sequencing: IDLE -> LEAD -> XFER -> TRAIL -> DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = LEAD;
            LEAD:    if (half_done) state_d = XFER;
            XFER:    if (last_edge) state_d = TRAIL;
            TRAIL:   if (half_done) state_d = DONE;
            DONE:                   state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Transmit shifter, mosi and chip selects. CPHA=0 presents the first bit
    // at accept and advances on even edges (not after the last one); CPHA=1
    // presents each bit on odd edges.
    always_comb begin
        mode_d = mode_q;
        tx_d   = tx_q;
        mosi_d = mosi_q;
        cs_n_d = cs_n_q;
        if (accept) begin
            mode_d = mode_in;
            cs_n_d = cs_decode(cs_sel);
            if (!mode_in.cpha) begin
                mosi_d = first_bit(din);
                tx_d   = shift_tx(din);
            end else begin
                tx_d   = din;
            end
        end else if (run) begin
            if ((!mode_q.cpha && trail_edge && !last_edge) ||
                (mode_q.cpha && lead_edge)) begin
                mosi_d = first_bit(tx_q);
                tx_d   = shift_tx(tx_q);
            end
        end else if (enter_done) begin
            cs_n_d = '1;
            mosi_d = 1'b0;
        end
    end

    // Control and transmit registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= '0;
            tx_q    <= '0;
            mosi_q  <= 1'b0;
            cs_n_q  <= '1;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            tx_q    <= tx_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
        end
    end

`ifdef SPI_RX_EN
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              sample;

    // miso is captured on the edge opposite to the one that launches mosi.
    assign sample = mode_q.cpha ? trail_edge : lead_edge;
    assign dout   = dout_q;

    // Receive shifter in transmit bit order; dout takes it as DONE is entered.
    always_comb begin
        rx_d   = rx_q;
        dout_d = dout_q;
        if (accept) begin
            rx_d = '0;
        end else if (sample) begin
            rx_d = (LSB_FIRST != 0) ? {miso, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], miso};
        end
        if (enter_done) begin
            dout_d = rx_q;
        end
    end

    // Receive registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_q   <= '0;
            dout_q <= '0;
        end else begin
            rx_q   <= rx_d;
            dout_q <= dout_d;
        end
    end
`else
    logic unused_miso;
    assign unused_miso = miso;
    assign dout        = '0;
`endif

endmodule

// File: tb/tb_spi_master_mc.sv
// Bench for spi_master_mc. dut_a: DATA_W=12, CLK_DIV=10, NUM_CS=4, MSB first,
// miso looped from mosi. dut_b: DATA_W=12, CLK_DIV=2, NUM_CS=3, LSB first,
// miso looped from ~mosi. Expected dout depends on SPI_RX_EN.
module tb_spi_master_mc;

`ifdef SPI_RX_EN
    localparam bit RX_EN = 1'b1;
`else
    localparam bit RX_EN = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // dut_a signals
    logic        start_a = 1'b0;
    logic [11:0] din_a = '0;
    logic [1:0]  mode_a = '0;
    logic [1:0]  cs_sel_a = '0;
    logic        miso_a, ready_a, done_a, sclk_a, mosi_a;
    logic [11:0] dout_a;
    logic [3:0]  cs_n_a;

    // dut_b signals
    logic        start_b = 1'b0;
    logic [11:0] din_b = '0;
    logic [1:0]  mode_b = '0;
    logic [1:0]  cs_sel_b = '0;
    logic        miso_b, ready_b, done_b, sclk_b, mosi_b;
    logic [11:0] dout_b;
    logic [2:0]  cs_n_b;

    assign miso_a = mosi_a;
    assign miso_b = ~mosi_b;

    // Monitor view of whichever DUT the current transfer drives.
    logic       sel_b = 1'b0;
    logic       mon_sclk, mon_mosi, mon_done, mon_ready;
    logic [3:0] mon_cs;
    assign mon_sclk  = sel_b ? sclk_b  : sclk_a;
    assign mon_mosi  = sel_b ? mosi_b  : mosi_a;
    assign mon_done  = sel_b ? done_b  : done_a;
    assign mon_ready = sel_b ? ready_b : ready_a;
    assign mon_cs    = sel_b ? {1'b1, cs_n_b} : cs_n_a;

    always #5 clk = ~clk;

    spi_master_mc #(.DATA_W(12), .CLK_DIV(10), .NUM_CS(4), .LSB_FIRST(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .din(din_a), .mode(mode_a),
        .cs_sel(cs_sel_a), .miso(miso_a), .ready(ready_a), .done(done_a),
        .dout(dout_a), .sclk(sclk_a), .cs_n(cs_n_a), .mosi(mosi_a)
    );

    spi_master_mc #(.DATA_W(12), .CLK_DIV(2), .NUM_CS(3), .LSB_FIRST(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .din(din_b), .mode(mode_b),
        .cs_sel(cs_sel_b), .miso(miso_b), .ready(ready_b), .done(done_b),
        .dout(dout_b), .sclk(sclk_b), .cs_n(cs_n_b), .mosi(mosi_b)
    );

    // Driver/monitor: issue one transfer and record what the wire shows.
    // Cycle 0 is the negedge where start is presented; t_done is the number
    // of negedges later at which done is seen high (-1 on timeout).
    task automatic xfer(input logic use_b, input logic [11:0] d, input logic [1:0] m,
                        input logic [1:0] cs, output int t_done, output int cs_low,
                        output int cs_other, output logic [11:0] cap_r,
                        output logic [11:0] cap_f, output int n_edges,
                        output int rdy_busy, output logic mosi_end, output logic sclk_end);
        logic       prev;
        logic [3:0] pat;
        sel_b = use_b;
        pat = ~(4'b0001 << cs);
        t_done = -1; cs_low = 0; cs_other = 0; cap_r = '0; cap_f = '0;
        n_edges = 0; rdy_busy = 0; mosi_end = 1'bx; sclk_end = 1'bx;
        @(negedge clk);
        if (use_b) begin
            start_b = 1'b1; din_b = d; mode_b = m; cs_sel_b = cs;
        end else begin
            start_a = 1'b1; din_a = d; mode_a = m; cs_sel_a = cs;
        end
        prev = mon_sclk;
        for (int n = 1; n <= 700; n++) begin
            @(negedge clk);
            start_a = 1'b0;
            start_b = 1'b0;
            if (mon_sclk !== prev) begin
                n_edges++;
                if (mon_sclk) cap_r = {cap_r[10:0], mon_mosi};
                else          cap_f = {cap_f[10:0], mon_mosi};
            end
            prev = mon_sclk;
            if (mon_cs != 4'hF) begin
                if (mon_cs == pat) cs_low++;
                else               cs_other++;
            end
            if (mon_done) begin
                t_done = n; mosi_end = mon_mosi; sclk_end = mon_sclk;
                break;
            end
            if (mon_ready) rdy_busy++;
        end
        if (t_done < 0) $display("FAIL xfer_timeout act=no_done exp=done_within_700");
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (ready_a !== 1'b1) begin failures++; $display("FAIL reset_ready act=%b exp=1", ready_a); end
        checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL reset_done act=%b exp=0", done_a); end
        checks++; if (dout_a !== 12'h000) begin failures++; $display("FAIL reset_dout act=%h exp=000", dout_a); end
        checks++; if (sclk_a !== 1'b0) begin failures++; $display("FAIL reset_sclk act=%b exp=0", sclk_a); end
        checks++; if (cs_n_a !== 4'hF) begin failures++; $display("FAIL reset_cs_n act=%h exp=f", cs_n_a); end
        checks++; if (mosi_a !== 1'b0) begin failures++; $display("FAIL reset_mosi act=%b exp=0", mosi_a); end
        checks++; if (cs_n_b !== 3'h7) begin failures++; $display("FAIL reset_cs_n_b act=%h exp=7", cs_n_b); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mode0();
        int t, cl, co, ne, rb; logic [11:0] cr, cf; logic me, se;
        xfer(1'b0, 12'hA5C, 2'd0, 2'd0, t, cl, co, cr, cf, ne, rb, me, se);
        checks++; if (t != 261) begin failures++; $display("FAIL m0_done_latency act=%0d exp=261", t); end
        checks++; if (cl != 260) begin failures++; $display("FAIL m0_cs_low_cycles act=%0d exp=260", cl); end
        checks++; if (co != 0) begin failures++; $display("FAIL m0_cs_wrong act=%0d exp=0", co); end
        checks++; if (cr !== 12'hA5C) begin failures++; $display("FAIL m0_mosi_bits act=%h exp=a5c", cr); end
        checks++; if (ne != 24) begin failures++; $display("FAIL m0_sclk_edges act=%0d exp=24", ne); end
        checks++; if (rb != 0) begin failures++; $display("FAIL m0_ready_busy act=%0d exp=0", rb); end
        checks++; if (me !== 1'b0) begin failures++; $display("FAIL m0_mosi_at_done act=%b exp=0", me); end
        checks++; if (dout_a !== (RX_EN ? 12'hA5C : 12'h000)) begin failures++; $display("FAIL m0_dout act=%h exp=%h", dout_a, RX_EN ? 12'hA5C : 12'h000); end
        @(negedge clk);
        checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL m0_done_width act=%b exp=0", done_a); end
        checks++; if (sclk_a !== 1'b0) begin failures++; $display("FAIL m0_sclk_idle act=%b exp=0", sclk_a); end
    endtask

    task automatic test_mode3_loop();
        int t, cl, co, ne, rb; logic [11:0] cr, cf; logic me, se;
        xfer(1'b0, 12'h3C9, 2'd3, 2'd1, t, cl, co, cr, cf, ne, rb, me, se);
        checks++; if (t != 261) begin failures++; $display("FAIL m3_done_latency act=%0d exp=261", t); end
        checks++; if (cl != 260 || co != 0) begin failures++; $display("FAIL m3_cs1 act=%0d/%0d exp=260/0", cl, co); end
        checks++; if (cr !== 12'h3C9) begin failures++; $display("FAIL m3_mosi_bits act=%h exp=3c9", cr); end
        checks++; if (se !== 1'b1) begin failures++; $display("FAIL m3_sclk_at_done act=%b exp=1", se); end
        checks++; if (dout_a !== (RX_EN ? 12'h3C9 : 12'h000)) begin failures++; $display("FAIL m3_dout act=%h exp=%h", dout_a, RX_EN ? 12'h3C9 : 12'h000); end
        repeat (5) @(negedge clk);
        checks++; if (sclk_a !== 1'b1) begin failures++; $display("FAIL m3_sclk_idle act=%b exp=1", sclk_a); end
        checks++; if (dout_a !== (RX_EN ? 12'h3C9 : 12'h000)) begin failures++; $display("FAIL m3_dout_hold act=%h exp=%h", dout_a, RX_EN ? 12'h3C9 : 12'h000); end
    endtask

    task automatic test_cs_sel();
        int t, cl, co, ne, rb; logic [11:0] cr, cf; logic me, se;
        xfer(1'b0, 12'h5A3, 2'd2, 2'd2, t, cl, co, cr, cf, ne, rb, me, se);
        checks++; if (cl != 260) begin failures++; $display("FAIL cs2_low_cycles act=%0d exp=260", cl); end
        checks++; if (co != 0) begin failures++; $display("FAIL cs2_other_bits act=%0d exp=0", co); end
        checks++; if (cf !== 12'h5A3) begin failures++; $display("FAIL m2_mosi_bits act=%h exp=5a3", cf); end
        checks++; if (se !== 1'b1) begin failures++; $display("FAIL m2_sclk_at_done act=%b exp=1", se); end
    endtask

    task automatic test_lsb_first();
        int t, cl, co, ne, rb; logic [11:0] cr, cf; logic me, se;
        xfer(1'b1, 12'h001, 2'd1, 2'd0, t, cl, co, cr, cf, ne, rb, me, se);
        checks++; if (t != 53) begin failures++; $display("FAIL lsb_done_latency act=%0d exp=53", t); end
        checks++; if (cl != 52 || co != 0) begin failures++; $display("FAIL lsb_cs0 act=%0d/%0d exp=52/0", cl, co); end
        checks++; if (cf !== 12'h800) begin failures++; $display("FAIL lsb_mosi_bits act=%h exp=800", cf); end
        checks++; if (dout_b !== (RX_EN ? 12'hFFE : 12'h000)) begin failures++; $display("FAIL lsb_dout act=%h exp=%h", dout_b, RX_EN ? 12'hFFE : 12'h000); end
    endtask

    task automatic test_cs_none();
        int t, cl, co, ne, rb; logic [11:0] cr, cf; logic me, se;
        xfer(1'b1, 12'hABC, 2'd0, 2'd3, t, cl, co, cr, cf, ne, rb, me, se);
        checks++; if (cl != 0 || co != 0) begin failures++; $display("FAIL csnone_any_low act=%0d/%0d exp=0/0", cl, co); end
        checks++; if (t != 53) begin failures++; $display("FAIL csnone_done act=%0d exp=53", t); end
        checks++; if (cr !== 12'h3D5) begin failures++; $display("FAIL csnone_mosi_bits act=%h exp=3d5", cr); end
    endtask

    task automatic test_back_to_back();
        int dones, t1, t2, rdy_cnt, rdy_at, gap;
        dones = 0; t1 = -1; t2 = -1; rdy_cnt = 0; rdy_at = -1; gap = 0;
        sel_b = 1'b0;
        @(negedge clk);
        start_a = 1'b1; din_a = 12'h0F0; mode_a = 2'd0; cs_sel_a = 2'd0;
        for (int n = 1; n <= 800; n++) begin
            @(negedge clk);
            if (done_a) begin
                dones++;
                if (dones == 1) t1 = n; else t2 = n;
            end
            if (dones == 1 && cs_n_a[0]) gap++;
            if (ready_a) begin rdy_cnt++; rdy_at = n; end
            if (dones >= 2) break;
        end
        start_a = 1'b0;
        checks++; if (t1 != 261) begin failures++; $display("FAIL b2b_first_done act=%0d exp=261", t1); end
        checks++; if (t2 != 523) begin failures++; $display("FAIL b2b_second_done act=%0d exp=523", t2); end
        checks++; if (rdy_cnt != 1 || rdy_at != 262) begin failures++; $display("FAIL b2b_ready act=%0d@%0d exp=1@262", rdy_cnt, rdy_at); end
        checks++; if (gap != 2) begin failures++; $display("FAIL b2b_cs_gap act=%0d exp=2", gap); end
        repeat (3) @(negedge clk);
        checks++; if (ready_a !== 1'b1 || cs_n_a !== 4'hF) begin failures++; $display("FAIL b2b_no_third act=%b/%h exp=1/f", ready_a, cs_n_a); end
    endtask

    task automatic test_reset_mid();
        int edges, extra_done, t, cl, co, ne, rb; logic [11:0] cr, cf; logic prev, me, se;
        edges = 0; extra_done = 0;
        sel_b = 1'b0;
        @(negedge clk);
        start_a = 1'b1; din_a = 12'hFFF; mode_a = 2'd0; cs_sel_a = 2'd0;
        prev = sclk_a;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (sclk_a !== prev) edges++;
            prev = sclk_a;
            if (edges == 7) break;
        end
        checks++; if (edges != 7 || sclk_a !== 1'b1 || mosi_a !== 1'b1) begin failures++; $display("FAIL rst_reach_edge7 act=%0d/%b/%b exp=7/1/1", edges, sclk_a, mosi_a); end
        rst_n = 1'b0;
        #1;
        checks++; if (cs_n_a !== 4'hF) begin failures++; $display("FAIL rst_cs_n act=%h exp=f", cs_n_a); end
        checks++; if (sclk_a !== 1'b0) begin failures++; $display("FAIL rst_sclk act=%b exp=0", sclk_a); end
        checks++; if (mosi_a !== 1'b0) begin failures++; $display("FAIL rst_mosi act=%b exp=0", mosi_a); end
        checks++; if (ready_a !== 1'b1) begin failures++; $display("FAIL rst_ready act=%b exp=1", ready_a); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (done_a) extra_done++;
        end
        checks++; if (extra_done != 0) begin failures++; $display("FAIL rst_no_done act=%0d exp=0", extra_done); end
        xfer(1'b0, 12'h6B1, 2'd0, 2'd0, t, cl, co, cr, cf, ne, rb, me, se);
        checks++; if (t != 261) begin failures++; $display("FAIL rst_fresh_done act=%0d exp=261", t); end
        checks++; if (cr !== 12'h6B1) begin failures++; $display("FAIL rst_fresh_bits act=%h exp=6b1", cr); end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode3_loop();
        test_cs_sel();
        test_lsb_first();
        test_cs_none();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
